mem_stream_reader: RTL

- Command-driven reader for the read port of the matrix multiplier's dual-port operand memory.
- Accepts a command (base, count, stride), walks the address sequence on r_addr, and captures the asynchronous-read r_data into an output register.
- Presents the captured words as a valid/ready stream to the multiplier datapath, with a last marker and a completion pulse.
- Pairs with the memory's read port: the memory responds, this block initiates.

---
 rtl/mm_mem_pkg.sv | 16 +
 rtl/mem_stream_reader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mm_mem_pkg.sv
// Shared definitions for the matrix-multiplier operand memory and the blocks
// that access it. The mock memory, the stream reader and a future writer all use these.
package mm_mem_pkg;

    // Default memory geometry: one 256-bit row/column slice per word, 1024 words.
    localparam int MM_DATA_WIDTH = 256;
    localparam int MM_ADDR_WIDTH = 10;

    // Reader control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } reader_state_e;

endpackage : mm_mem_pkg

// File: rtl/mem_stream_reader.sv
// Command-driven reader for the operand memory read port.
// It accepts (base, count, stride) and walks the address sequence on r_addr.
// It captures the asynchronous read data into an output register and presents
// the words as a valid/ready stream with a last marker and a completion pulse.
module mem_stream_reader
    import mm_mem_pkg::*;
#(
    parameter int DATA_WIDTH = MM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
    parameter int CNT_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic [ADDR_WIDTH-1:0] cmd_stride,
    // memory read port
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_data,
    // output stream
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    // status
    output logic                  busy,
    output logic                  done
);

    reader_state_e         state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [CNT_WIDTH-1:0]  remaining_q;
    logic [CNT_WIDTH-1:0]  remaining_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  done_q;
    logic                  load;

    // Next address wraps modulo the memory depth by truncation; next count is one fewer word.
    assign addr_d      = addr_q + stride_q;
    assign remaining_d = remaining_q - CNT_WIDTH'(1);

    // Capture a word whenever words remain and the output register is empty or draining.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        load = 1'b0;
        if (state_q == RUN) begin
            load = (remaining_q != '0) && (!out_valid_q || out_ready);
        end
    end

    // Reader FSM with the address walker, beat counter and registered stream outputs.
    always_ff @(posedge clk) begin
        // NOTE: the wide data register is reset as well, so out_data reads 0 after reset
        // instead of stale contents; reset is sampled on the clock edge, not asynchronously.
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // done is a single-cycle pulse: it is only raised on the transition into FIN.
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_base;
                        remaining_q <= cmd_count;
                        stride_q    <= cmd_stride;
                        if (cmd_count == '0) begin
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        // NOTE: non-blocking assignments so every register sees pre-edge values.
                        out_data_q  <= r_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (remaining_q == CNT_WIDTH'(1));
                        addr_q      <= addr_d;
                        remaining_q <= remaining_d;
                    end else if (out_valid_q && out_ready) begin
                        // The register drains with nothing left to load. If that was the
                        // final beat, the command is complete.
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            out_last_q <= 1'b0;
                            state_q    <= FIN;
                            done_q     <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign r_addr    = addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign done      = done_q;

endmodule : mem_stream_reader
